// File: rtl/msrv32_machine_control.sv
// Trap/exception sequencer for the MS-RV32 core: detects traps and mret, steers PC source,
// flushes the pipe and strobes the CSR file through a four-state machine.
module msrv32_machine_control (
    input  logic       ms_riscv32_mp_clk_in,
    input  logic       ms_riscv32_mp_rst_n_in,
    input  logic       illegal_instr_in,
    input  logic       misaligned_load_in,
    input  logic       misaligned_store_in,
    input  logic       misaligned_instr_in,
    input  logic [4:0] opcode_6_to_2_in,
    input  logic [2:0] funct3_in,
    input  logic [6:0] funct7_in,
    input  logic [4:0] rs1_addr_in,
    input  logic [4:0] rs2_addr_in,
    input  logic [4:0] rd_addr_in,
    input  logic       mie_in,
    input  logic       meie_in,
    input  logic       mtie_in,
    input  logic       msie_in,
    input  logic       meip_in,
    input  logic       mtip_in,
    input  logic       msip_in,
    output logic       trap_taken_out,
    output logic [1:0] pc_src_out,
    output logic       flush_out,
    output logic       set_cause_out,
    output logic       set_epc_out,
    output logic [3:0] cause_out,
    output logic       i_or_e_out,
    output logic       mie_clear_out,
    output logic       mie_set_out,
    output logic       instret_inc_out,
    output logic       misaligned_exception_out
);

    typedef enum logic [1:0] {
        StReset      = 2'b00,
        StOperating  = 2'b01,
        StTrapTaken  = 2'b10,
        StTrapReturn = 2'b11
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cause_q, cause_d;
    logic       i_or_e_q, i_or_e_d;
    logic       mis_exc_q, mis_exc_d;

    logic system_base;
    logic is_ecall, is_ebreak, is_mret;
    logic ext_irq, sw_irq, tmr_irq;
    logic irq, exc, trap;

    // ecall/ebreak/mret share the SYSTEM opcode with zero funct3, rs1 and rd.
    assign system_base = (opcode_6_to_2_in == 5'b11100) && (funct3_in == 3'b000) &&
                         (rs1_addr_in == 5'd0) && (rd_addr_in == 5'd0);
    assign is_ecall    = system_base && (funct7_in == 7'b0000000) && (rs2_addr_in == 5'd0);
    assign is_ebreak   = system_base && (funct7_in == 7'b0000000) && (rs2_addr_in == 5'd1);
    assign is_mret     = system_base && (funct7_in == 7'b0011000) && (rs2_addr_in == 5'd2);

    assign ext_irq = mie_in & meie_in & meip_in;
    assign sw_irq  = mie_in & msie_in & msip_in;
    assign tmr_irq = mie_in & mtie_in & mtip_in;
    assign irq     = ext_irq | sw_irq | tmr_irq;
    assign exc     = misaligned_instr_in | illegal_instr_in | is_ecall | is_ebreak |
                     misaligned_load_in | misaligned_store_in;
    assign trap    = irq | exc;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StReset:      state_d = StOperating;
            StOperating: begin
                if (trap) begin
                    state_d = StTrapTaken;
                end else if (is_mret) begin
                    state_d = StTrapReturn;
                end
            end
            StTrapTaken:  state_d = StOperating;
            StTrapReturn: state_d = StOperating;
            default:      state_d = StReset;
        endcase
    end

    // Cause priority: interrupts first (external, software, timer), then synchronous exceptions.
    always_comb begin
        cause_d  = 4'b0000;
        i_or_e_d = 1'b0;
        if (ext_irq) begin
            cause_d  = 4'b1011;
            i_or_e_d = 1'b1;
        end else if (sw_irq) begin
            cause_d  = 4'b0011;
            i_or_e_d = 1'b1;
        end else if (tmr_irq) begin
            cause_d  = 4'b0111;
            i_or_e_d = 1'b1;
        end else if (misaligned_instr_in) begin
            cause_d  = 4'b0000;
        end else if (illegal_instr_in) begin
            cause_d  = 4'b0010;
        end else if (is_ebreak) begin
            cause_d  = 4'b0011;
        end else if (is_ecall) begin
            cause_d  = 4'b1011;
        end else if (misaligned_load_in) begin
            cause_d  = 4'b0100;
        end else if (misaligned_store_in) begin
            cause_d  = 4'b0110;
        end
        mis_exc_d = ~i_or_e_d &
                    ((cause_d == 4'b0000) || (cause_d == 4'b0100) || (cause_d == 4'b0110));
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state_q   <= StReset;
            cause_q   <= 4'b0000;
            i_or_e_q  <= 1'b0;
            mis_exc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StOperating && trap) begin
                cause_q   <= cause_d;
                i_or_e_q  <= i_or_e_d;
                mis_exc_q <= mis_exc_d;
            end
        end
    end

    always_comb begin
        trap_taken_out  = 1'b0;
        pc_src_out      = 2'b00;
        flush_out       = 1'b0;
        set_cause_out   = 1'b0;
        set_epc_out     = 1'b0;
        mie_clear_out   = 1'b0;
        mie_set_out     = 1'b0;
        instret_inc_out = 1'b0;
        unique case (state_q)
            StReset: begin
                pc_src_out = 2'b00;
                flush_out  = 1'b1;
            end
            StOperating: begin
                pc_src_out      = 2'b11;
                trap_taken_out  = trap;
                instret_inc_out = ~trap;
            end
            StTrapTaken: begin
                pc_src_out    = 2'b10;
                flush_out     = 1'b1;
                set_cause_out = 1'b1;
                set_epc_out   = 1'b1;
                mie_clear_out = 1'b1;
            end
            StTrapReturn: begin
                pc_src_out  = 2'b01;
                flush_out   = 1'b1;
                mie_set_out = 1'b1;
            end
            default: begin
                pc_src_out = 2'b00;
                flush_out  = 1'b1;
            end
        endcase
    end

    assign cause_out                = cause_q;
    assign i_or_e_out               = i_or_e_q;
    assign misaligned_exception_out = mis_exc_q;

endmodule

// File: tb/tb_msrv32_machine_control.sv
// Directed bench for msrv32_machine_control; inputs change 1ns after the rising edge and
// outputs are sampled 1ns later, away from the edge.
module tb_msrv32_machine_control;

    logic       clk;
    logic       rst_n;
    logic       illegal, mis_load, mis_store, mis_instr;
    logic [4:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1, rs2, rd;
    logic       mie, meie, mtie, msie, meip, mtip, msip;
    logic       trap_taken;
    logic [1:0] pc_src;
    logic       flush, set_cause, set_epc;
    logic [3:0] cause;
    logic       i_or_e, mie_clear, mie_set, instret_inc, mis_exc;

    int n_checks = 0;
    int n_fail   = 0;

    msrv32_machine_control dut (
        .ms_riscv32_mp_clk_in    (clk),
        .ms_riscv32_mp_rst_n_in  (rst_n),
        .illegal_instr_in        (illegal),
        .misaligned_load_in      (mis_load),
        .misaligned_store_in     (mis_store),
        .misaligned_instr_in     (mis_instr),
        .opcode_6_to_2_in        (opcode),
        .funct3_in               (funct3),
        .funct7_in               (funct7),
        .rs1_addr_in             (rs1),
        .rs2_addr_in             (rs2),
        .rd_addr_in              (rd),
        .mie_in                  (mie),
        .meie_in                 (meie),
        .mtie_in                 (mtie),
        .msie_in                 (msie),
        .meip_in                 (meip),
        .mtip_in                 (mtip),
        .msip_in                 (msip),
        .trap_taken_out          (trap_taken),
        .pc_src_out              (pc_src),
        .flush_out               (flush),
        .set_cause_out           (set_cause),
        .set_epc_out             (set_epc),
        .cause_out               (cause),
        .i_or_e_out              (i_or_e),
        .mie_clear_out           (mie_clear),
        .mie_set_out             (mie_set),
        .instret_inc_out         (instret_inc),
        .misaligned_exception_out(mis_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        illegal = 0; mis_load = 0; mis_store = 0; mis_instr = 0;
        opcode = 5'b01100; funct3 = 0; funct7 = 0; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3;
        mie = 0; meie = 0; mtie = 0; msie = 0; meip = 0; mtip = 0; msip = 0;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_system(input logic [6:0] f7, input logic [4:0] r2);
        opcode = 5'b11100; funct3 = 3'b000; funct7 = f7; rs1 = 0; rs2 = r2; rd = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_inputs();
        tick(); tick(); tick();
        #1;
        n_checks++; if (pc_src !== 2'b00) begin n_fail++; $display("FAIL rst_pc_src got %b want 00", pc_src); end
        n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL rst_flush got %b want 1", flush); end
        n_checks++; if (cause !== 4'b0000) begin n_fail++; $display("FAIL rst_cause got %b want 0000", cause); end
        n_checks++; if (instret_inc !== 1'b0 || trap_taken !== 1'b0 || set_cause !== 1'b0)
            begin n_fail++; $display("FAIL rst_strobes got %b%b%b want 000", instret_inc, trap_taken, set_cause); end
        rst_n = 1;
        tick();
        #1;
        n_checks++; if (pc_src !== 2'b11) begin n_fail++; $display("FAIL rel_pc_src got %b want 11", pc_src); end
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL rel_flush got %b want 0", flush); end
        n_checks++; if (instret_inc !== 1'b1) begin n_fail++; $display("FAIL rel_instret got %b want 1", instret_inc); end
    endtask

    task automatic test_illegal();
        clear_inputs();
        illegal = 1;
        #1;
        n_checks++; if (trap_taken !== 1'b1) begin n_fail++; $display("FAIL ill_trap_taken got %b want 1", trap_taken); end
        n_checks++; if (instret_inc !== 1'b0) begin n_fail++; $display("FAIL ill_instret got %b want 0", instret_inc); end
        tick();
        clear_inputs();
        #1;
        n_checks++; if (cause !== 4'b0010 || i_or_e !== 1'b0)
            begin n_fail++; $display("FAIL ill_cause got %b/%b want 0010/0", cause, i_or_e); end
        n_checks++; if ({set_cause, set_epc, mie_clear} !== 3'b111)
            begin n_fail++; $display("FAIL ill_strobes got %b%b%b want 111", set_cause, set_epc, mie_clear); end
        n_checks++; if (pc_src !== 2'b10 || flush !== 1'b1)
            begin n_fail++; $display("FAIL ill_pc_flush got %b/%b want 10/1", pc_src, flush); end
        n_checks++; if (trap_taken !== 1'b0 || mie_set !== 1'b0)
            begin n_fail++; $display("FAIL ill_tt_quiet got %b/%b want 0/0", trap_taken, mie_set); end
        tick();
        #1;
        n_checks++; if (pc_src !== 2'b11) begin n_fail++; $display("FAIL ill_return got %b want 11", pc_src); end
        n_checks++; if (cause !== 4'b0010) begin n_fail++; $display("FAIL ill_cause_hold got %b want 0010", cause); end
    endtask

    task automatic test_mret();
        clear_inputs();
        set_system(7'b0011000, 5'd2);
        #1;
        n_checks++; if (trap_taken !== 1'b0) begin n_fail++; $display("FAIL mret_tt0 got %b want 0", trap_taken); end
        tick();
        clear_inputs();
        #1;
        n_checks++; if (pc_src !== 2'b01 || mie_set !== 1'b1 || flush !== 1'b1)
            begin n_fail++; $display("FAIL mret_ret got %b/%b/%b want 01/1/1", pc_src, mie_set, flush); end
        n_checks++; if (trap_taken !== 1'b0 || set_cause !== 1'b0 || mie_clear !== 1'b0)
            begin n_fail++; $display("FAIL mret_quiet got %b%b%b want 000", trap_taken, set_cause, mie_clear); end
        tick();
        #1;
        n_checks++; if (pc_src !== 2'b11) begin n_fail++; $display("FAIL mret_back got %b want 11", pc_src); end
    endtask

    task automatic test_priority();
        clear_inputs();
        mie = 1; meie = 1; meip = 1; mtie = 1; mtip = 1; mis_load = 1;
        tick();
        clear_inputs();
        #1;
        n_checks++; if (cause !== 4'b1011 || i_or_e !== 1'b1 || mis_exc !== 1'b0)
            begin n_fail++; $display("FAIL pri_ext got %b/%b/%b want 1011/1/0", cause, i_or_e, mis_exc); end
        tick();
        mie = 1; msie = 1; msip = 1; mtie = 1; mtip = 1; illegal = 1;
        tick();
        clear_inputs();
        #1;
        n_checks++; if (cause !== 4'b0011 || i_or_e !== 1'b1)
            begin n_fail++; $display("FAIL pri_sw got %b/%b want 0011/1", cause, i_or_e); end
        tick();
        mis_instr = 1; illegal = 1; mis_store = 1;
        tick();
        clear_inputs();
        #1;
        n_checks++; if (cause !== 4'b0000 || i_or_e !== 1'b0 || mis_exc !== 1'b1)
            begin n_fail++; $display("FAIL pri_misinstr got %b/%b/%b want 0000/0/1", cause, i_or_e, mis_exc); end
        tick();
    endtask

    task automatic test_masked_irq();
        clear_inputs();
        mie = 0; mtie = 1; mtip = 1; meie = 1; meip = 1;
        #1;
        n_checks++; if (trap_taken !== 1'b0 || instret_inc !== 1'b1)
            begin n_fail++; $display("FAIL mask_irq got %b/%b want 0/1", trap_taken, instret_inc); end
        tick();
        n_checks++; if (pc_src !== 2'b11) begin n_fail++; $display("FAIL mask_hold got %b want 11", pc_src); end
        set_system(7'b0000000, 5'd0);
        #1;
        n_checks++; if (trap_taken !== 1'b1) begin n_fail++; $display("FAIL ecall_tt got %b want 1", trap_taken); end
        tick();
        clear_inputs();
        #1;
        n_checks++; if (cause !== 4'b1011 || i_or_e !== 1'b0 || mis_exc !== 1'b0)
            begin n_fail++; $display("FAIL ecall_cause got %b/%b/%b want 1011/0/0", cause, i_or_e, mis_exc); end
        tick();
        mis_store = 1;
        tick();
        clear_inputs();
        #1;
        n_checks++; if (cause !== 4'b0110 || mis_exc !== 1'b1)
            begin n_fail++; $display("FAIL mstore_cause got %b/%b want 0110/1", cause, mis_exc); end
        tick();
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        mis_load = 1;
        tick();
        clear_inputs();
        #1;
        n_checks++; if (cause !== 4'b0100 || mis_exc !== 1'b1)
            begin n_fail++; $display("FAIL b2b_first got %b/%b want 0100/1", cause, mis_exc); end
        tick();
        set_system(7'b0000000, 5'd1);
        #1;
        n_checks++; if (trap_taken !== 1'b1 || pc_src !== 2'b11)
            begin n_fail++; $display("FAIL b2b_tt got %b/%b want 1/11", trap_taken, pc_src); end
        tick();
        clear_inputs();
        #1;
        n_checks++; if (cause !== 4'b0011 || i_or_e !== 1'b0 || mis_exc !== 1'b0 || pc_src !== 2'b10)
            begin n_fail++; $display("FAIL b2b_ebreak got %b/%b/%b/%b want 0011/0/0/10", cause, i_or_e, mis_exc, pc_src); end
        tick();
    endtask

    task automatic test_reset_mid_trap();
        clear_inputs();
        illegal = 1;
        tick();
        clear_inputs();
        rst_n = 0;
        #1;
        n_checks++; if (pc_src !== 2'b10) begin n_fail++; $display("FAIL mid_in_trap got %b want 10", pc_src); end
        tick();
        #1;
        n_checks++; if (pc_src !== 2'b00 || flush !== 1'b1 || cause !== 4'b0000)
            begin n_fail++; $display("FAIL mid_reset got %b/%b/%b want 00/1/0000", pc_src, flush, cause); end
        n_checks++; if (set_cause !== 1'b0 || mie_clear !== 1'b0)
            begin n_fail++; $display("FAIL mid_strobes got %b/%b want 0/0", set_cause, mie_clear); end
        rst_n = 1;
        tick();
        #1;
        n_checks++; if (pc_src !== 2'b11) begin n_fail++; $display("FAIL mid_release got %b want 11", pc_src); end
    endtask

    task automatic test_trap_beats_mret();
        clear_inputs();
        set_system(7'b0011000, 5'd2);
        illegal = 1;
        #1;
        n_checks++; if (trap_taken !== 1'b1) begin n_fail++; $display("FAIL tbm_tt got %b want 1", trap_taken); end
        tick();
        clear_inputs();
        #1;
        n_checks++; if (pc_src !== 2'b10 || mie_set !== 1'b0 || cause !== 4'b0010)
            begin n_fail++; $display("FAIL tbm_state got %b/%b/%b want 10/0/0010", pc_src, mie_set, cause); end
        tick();
    endtask

    initial begin
        test_reset();
        test_illegal();
        test_mret();
        test_priority();
        test_masked_irq();
        test_back_to_back();
        test_reset_mid_trap();
        test_trap_beats_mret();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/msrv32_machine_control.md
# msrv32_machine_control

Trap/exception sequencer of the MS-RV32 core. It sits directly upstream of `msrv32_decoder`. It consumes the decoder's `illegal_instr_out`, `misaligned_load_out` and `misaligned_store_out`, plus the fetch-side misaligned flag and the interrupt lines. It drives `trap_taken_in` back into the decoder. It also drives the PC-source select, the pipeline flush and the CSR-file update strobes through a 4-state FSM.

## Interface
No parameters.
- ms_riscv32_mp_clk_in  input  1  core clock; all state updates on rising edge
- ms_riscv32_mp_rst_n_in  input  1  reset, synchronous, active-low
- illegal_instr_in  input  1  from decoder `illegal_instr_out`
- misaligned_load_in  input  1  from decoder `misaligned_load_out`
- misaligned_store_in  input  1  from decoder `misaligned_store_out`
- misaligned_instr_in  input  1  fetch target not word aligned
- opcode_6_to_2_in  input  5  instruction bits [6:2]
- funct3_in  input  3  instruction bits [14:12]
- funct7_in  input  7  instruction bits [31:25]
- rs1_addr_in, rs2_addr_in, rd_addr_in  input  5 each  instruction register fields
- mie_in  input  1  mstatus.MIE
- meie_in, mtie_in, msie_in  input  1 each  mie.MEIE/MTIE/MSIE
- meip_in, mtip_in, msip_in  input  1 each  mip.MEIP/MTIP/MSIP
- trap_taken_out  output  1  to decoder `trap_taken_in`
- pc_src_out  output  2  00 boot address, 01 mepc, 10 trap vector, 11 next PC
- flush_out  output  1  kill instruction in fetch/decode
- set_cause_out, set_epc_out  output  1 each  mcause/mepc write strobes
- cause_out  output  4  mcause code, registered
- i_or_e_out  output  1  1 = interrupt, 0 = exception, registered
- mie_clear_out, mie_set_out  output  1 each  mstatus.MIE clear/set strobes
- instret_inc_out  output  1  minstret increment
- misaligned_exception_out  output  1  the current trap is a misaligned one

## Operation
- State register is 2 bits: RESET=00, OPERATING=01, TRAP_TAKEN=10, TRAP_RETURN=11.
- Instruction decode:
  - ecall: opcode_6_to_2=11100, funct3=000, funct7=0000000, rs1=rs2=rd=0.
  - ebreak: same fields as ecall, except rs2=00001.
  - mret: same fields as ecall, except funct7=0011000 and rs2=00010.
- Interrupt pending: `irq = mie_in & ((meie_in&meip_in)|(msie_in&msip_in)|(mtie_in&mtip_in))`.
- Exception pending: `exc = misaligned_instr | illegal | ecall | ebreak | misaligned_load | misaligned_store`.
- `trap = irq | exc`.
- Transitions:
  - RESET→OPERATING unconditionally.
  - OPERATING→TRAP_TAKEN if trap.
  - OPERATING→TRAP_RETURN if mret and no trap. A trap beats mret.
  - Otherwise OPERATING holds.
  - TRAP_TAKEN→OPERATING and TRAP_RETURN→OPERATING unconditionally.
- cause_out / i_or_e_out are loaded on the OPERATING→TRAP_TAKEN edge only and hold otherwise. Priority is highest first:
  - external irq 1011/1
  - software irq 0011/1
  - timer irq 0111/1
  - misaligned_instr 0000/0
  - illegal 0010/0
  - ebreak 0011/0
  - ecall 1011/0
  - misaligned_load 0100/0
  - misaligned_store 0110/0
- misaligned_exception_out is registered together with cause. It is 1 when the latched exception cause is 0000, 0100 or 0110.
- Combinational outputs per state:
  - RESET: pc_src=00, flush=1, all strobes 0.
  - OPERATING: pc_src=11, flush=0, trap_taken_out=trap, instret_inc_out=~trap.
  - TRAP_TAKEN: pc_src=10, flush=1, set_cause=set_epc=mie_clear=1.
  - TRAP_RETURN: pc_src=01, flush=1, mie_set=1.
- Every output not listed for a state is 0.

## Timing
- Reset low at any edge, including mid-trap: the next state is RESET and cause_out=0000, i_or_e_out=0, misaligned_exception_out=0.
- While in RESET: pc_src=00, flush=1, all other outputs 0.
- First OPERATING cycle is the cycle after the first edge that samples reset high.
- trap_taken_out has zero latency: it is asserted in the same cycle as the offending instruction, so the decoder suppresses writes.
- The trap sequence occupies exactly one TRAP_TAKEN cycle after detection, then returns to OPERATING.
- mret occupies exactly one TRAP_RETURN cycle.
- Back-to-back traps: a trap condition present in the first OPERATING cycle after TRAP_TAKEN or TRAP_RETURN is taken normally.
- Interrupts with mie_in=0 are ignored.
- Exceptions are taken regardless of mie_in.

## Test plan
- Reset: rst_n low for 3 cycles, giving pc_src=00, flush=1, cause=0000. Release: the next cycle shows pc_src=11, flush=0, instret_inc=1.
- illegal_instr_in=1 in OPERATING with mie=0:
  - same cycle: trap_taken_out=1, instret_inc=0.
  - next cycle: cause=0010, i_or_e=0, set_cause=set_epc=mie_clear=1, pc_src=10, flush=1.
  - cycle after: pc_src=11.
- mret encoding (funct7=0011000, rs2=00010): next cycle pc_src=01, mie_set=1, flush=1; trap_taken_out stays 0 throughout.
- Simultaneous mie=1, meie=meip=1, mtie=mtip=1, misaligned_load=1: cause=1011, i_or_e=1, misaligned_exception=0.
- mie=0, mtie=mtip=1: no trap and instret_inc=1. Then ecall: cause=1011, i_or_e=0. Then misaligned_store: cause=0110, misaligned_exception=1.
- rst_n low during TRAP_TAKEN: next cycle is RESET with pc_src=00 and cause=0000. A trap and mret presented together produce TRAP_TAKEN, not TRAP_RETURN.
